// File: rtl/flag_fifo.sv
// rtl/flag_fifo.sv - 16x8 single-clock FIFO with empty/partially-empty/full/partially-full flags
module flag_fifo #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AE_LEVEL = 4,
   parameter int AF_LEVEL = 12
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             WE,
   input  logic             RE,
   output logic [WIDTH-1:0] DOUT,
   output logic             EF,
   output logic             PEF,
   output logic             FF,
   output logic             PFF
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ef_q, pef_q, ff_q, pff_q;

   logic             wr_en;
   logic             rd_en;

   // Each side is qualified by the flags as they stood before the edge.
   assign wr_en = WE && !ff_q;
   assign rd_en = RE && !ef_q;

   // Next-state for pointers, occupancy and read data.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      dout_d  = dout_q;
      if (wr_en) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (rd_en) begin
         rptr_d = rptr_q + AW'(1);
         dout_d = mem_q[rptr_q];
      end
      if (wr_en && !rd_en) begin
         count_d = count_q + CW'(1);
      end else if (rd_en && !wr_en) begin
         count_d = count_q - CW'(1);
      end
   end

   // Storage array; contents are not reset, and writes are blocked while in reset.
   always_ff @(posedge clk) begin
      if (wr_en && RESET) begin
         mem_q[wptr_q] <= DATA_IN;
      end
   end

   // Control state and registered flags derived from the next occupancy.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         ef_q    <= 1'b1;
         pef_q   <= 1'b1;
         ff_q    <= 1'b0;
         pff_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         ef_q    <= (count_d == '0);
         pef_q   <= (count_d <= AE_CNT);
         ff_q    <= (count_d == FULL_CNT);
         pff_q   <= (count_d >= AF_CNT);
      end
   end

   assign DOUT = dout_q;
   assign EF   = ef_q;
   assign PEF  = pef_q;
   assign FF   = ff_q;
   assign PFF  = pff_q;

endmodule

// File: tb/tb_flag_fifo.sv
// tb/tb_flag_fifo.sv - randomized directed bench for flag_fifo against a queue model
module tb_flag_fifo;

   logic       clk;
   logic       RESET;
   logic [7:0] DATA_IN;
   logic       WE;
   logic       RE;
   logic [7:0] DOUT;
   logic       EF, PEF, FF, PFF;

   int         total = 0;
   int         bad   = 0;

   logic [7:0] q[$];
   logic [7:0] mdout;

   flag_fifo dut (
      .clk     (clk),
      .RESET   (RESET),
      .DATA_IN (DATA_IN),
      .WE      (WE),
      .RE      (RE),
      .DOUT    (DOUT),
      .EF      (EF),
      .PEF     (PEF),
      .FF      (FF),
      .PFF     (PFF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".dout"}, DOUT, mdout);
      chkb({tag, ".ef"},  EF,  q.size() == 0);
      chkb({tag, ".pef"}, PEF, q.size() <= 4);
      chkb({tag, ".ff"},  FF,  q.size() == 16);
      chkb({tag, ".pff"}, PFF, q.size() >= 12);
   endtask

   task automatic model_reset();
      q.delete();
      mdout = 8'h00;
   endtask

   // One clock: drive inputs, update the model at the edge, check at the falling edge.
   task automatic cyc(input string tag, input logic we, input logic re, input logic [7:0] d);
      bit was_empty, was_full;
      WE      = we;
      RE      = re;
      DATA_IN = d;
      @(posedge clk);
      was_empty = (q.size() == 0);
      was_full  = (q.size() == 16);
      if (re && !was_empty) mdout = q.pop_front();
      if (we && !was_full)  q.push_back(d);
      @(negedge clk);
      chk_all(tag);
   endtask

   task automatic mid_reset(input string tag);
      #2;
      RESET = 1'b0;
      #1;
      model_reset();
      chk_all(tag);
      @(negedge clk);
      chk_all({tag, ".held"});
      RESET = 1'b1;
   endtask

   initial begin
      RESET   = 1'b0;
      WE      = 1'b0;
      RE      = 1'b0;
      DATA_IN = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      chk_all("por");
      RESET = 1'b1;

      // Some traffic, then reset between edges.
      for (int i = 0; i < 3; i++) cyc("pre", 1'b1, 1'b0, 8'($urandom));
      cyc("pre_rd", 1'b0, 1'b1, 8'h00);
      mid_reset("rst1");

      // Fill with 1,2,3,... for 20 clocks; the last four writes are dropped.
      for (int i = 1; i <= 20; i++) cyc("fill", 1'b1, 1'b0, 8'(i));

      // Drain 18 clocks; the last two reads are ignored and DOUT holds 16.
      for (int i = 0; i < 18; i++) cyc("drain", 1'b0, 1'b1, 8'h00);
      chk("drain_last", DOUT, 8'd16);

      // Simultaneous read/write while empty: only the write happens.
      cyc("we_re_empty", 1'b1, 1'b1, 8'($urandom));
      chkb("we_re_empty_ef", EF, 1'b0);
      chk("we_re_empty_dout", DOUT, 8'd16);

      // Fill up, then simultaneous read/write while full: only the read happens.
      for (int i = 0; i < 15; i++) cyc("refill", 1'b1, 1'b0, 8'($urandom));
      cyc("we_re_full", 1'b1, 1'b1, 8'($urandom));
      chkb("we_re_full_ff", FF, 1'b0);

      // Down to 8 entries, then 40 simultaneous cycles across the pointer wrap.
      while (q.size() > 8) cyc("to8", 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 40; i++) cyc("sim", 1'b1, 1'b1, 8'($urandom));
      chk("sim_count", 8'(q.size()), 8'd8);

      // Random mixed traffic.
      for (int i = 0; i < 300; i++) begin
         int r;
         r = int'($urandom_range(0, 3));
         cyc("rand", r[0], r[1], 8'($urandom));
      end

      // Bring occupancy to 10, reset between edges, then confirm a clean restart.
      while (q.size() < 10) cyc("to10w", 1'b1, 1'b0, 8'($urandom));
      while (q.size() > 10) cyc("to10r", 1'b0, 1'b1, 8'h00);
      mid_reset("rst2");
      cyc("post_wr", 1'b1, 1'b0, 8'hA5);
      cyc("post_rd", 1'b0, 1'b1, 8'h00);
      chk("post_dout", DOUT, 8'hA5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
